// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with flush, optional skid entry
// and a saturating stall counter for the performance monitors.
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SKID      = 1'b1,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic rdy_q, rdy_d;
   assign out_valid = state_q != ST_EMPTY;
   assign out_data  = main_q;
   assign stall_cnt = cnt_q;
   // with a skid entry the ready is registered, so upstream never sees out_ready
   assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = (out_valid && !out_ready && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      if (clear) begin
         state_d = ST_EMPTY;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_valid) begin
               main_d  = in_data;
               state_d = ST_FULL;
            end
            ST_FULL: if (in_valid && out_ready) main_d = in_data;
               else if (in_valid && SKID) begin
                  skid_d  = in_data;
                  state_d = ST_SKID;
               end else if (!in_valid && out_ready) state_d = ST_EMPTY;
            ST_SKID: if (out_ready) begin
               main_d  = skid_q;
               state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      rdy_d = state_d != ST_SKID;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
         cnt_q   <= '0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: vector table, corner sequences and a queue-model random run
// over a skid stage, a 4-bit-counter skid stage and a single-entry stage.
module tb_pipe_stage_elastic;
   localparam logic [31:0] RVA = 32'h0BADF00D;
   localparam logic [7:0]  RVB = 8'h5A;
   localparam logic [15:0] RVC = 16'h1234;
   logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, iv = 1'b0, ordy = 1'b0;
   logic [31:0] d = '0;
   logic rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
   logic [31:0] od_a;
   logic [7:0]  od_b;
   logic [15:0] od_c;
   logic [15:0] sc_a;
   logic [3:0]  sc_b;
   logic [7:0]  sc_c;
   int pass = 0, total = 0;
   always #5 clk = ~clk;
   pipe_stage_elastic #(.WIDTH(32), .RESET_VAL(RVA), .SKID(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy_a), .in_data(d),
      .out_valid(ov_a), .out_ready(ordy), .out_data(od_a), .stall_cnt(sc_a));
   pipe_stage_elastic #(.WIDTH(8), .RESET_VAL(RVB), .SKID(1'b1), .CNT_W(4)) u_b (
      .clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy_b), .in_data(d[7:0]),
      .out_valid(ov_b), .out_ready(ordy), .out_data(od_b), .stall_cnt(sc_b));
   pipe_stage_elastic #(.WIDTH(16), .RESET_VAL(RVC), .SKID(1'b0), .CNT_W(8)) u_c (
      .clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy_c), .in_data(d[15:0]),
      .out_valid(ov_c), .out_ready(ordy), .out_data(od_c), .stall_cnt(sc_c));
   typedef struct {
      logic iv; logic [31:0] d; logic r; logic c;
      logic ev; logic [31:0] ed; logic er; logic [15:0] es;
   } vec_t;
   vec_t tv [15];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h, want %h", n, act, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input logic v, input logic [31:0] dd, input logic r, input logic c);
      iv = v; d = dd; ordy = r; clr = c;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      set_in(1'b0, '0, 1'b0, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
   endtask
   logic [31:0] qa [$];
   logic [15:0] qc [$];
   logic [31:0] la;
   logic [15:0] lc;
   int ca, cc;
   logic era, erc;
   initial begin
      tv[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 16'd0};
      tv[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 1'b1, 16'd0};
      tv[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 16'd0};
      tv[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h33, 1'b1, 16'd0};
      tv[4]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1, 16'd0};
      tv[5]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 16'd1};
      tv[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 16'd2};
      tv[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b1, 16'd2};
      tv[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hA2, 1'b1, 16'd2};
      tv[9]  = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB1, 1'b1, 16'd2};
      tv[10] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 1'b0, 16'd3};
      tv[11] = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, RVA,    1'b1, 16'd4};
      tv[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, RVA,    1'b1, 16'd4};
      tv[13] = '{1'b1, 32'hE1, 1'b1, 1'b0, 1'b1, 32'hE1, 1'b1, 16'd4};
      tv[14] = '{1'b1, 32'hE2, 1'b1, 1'b1, 1'b0, RVA,    1'b1, 16'd4};
      do_reset();
      chk("rst ov_a", 32'(ov_a), 32'd0);
      chk("rst od_a", od_a, RVA);
      chk("rst rdy_a", 32'(rdy_a), 32'd1);
      chk("rst sc_a", 32'(sc_a), 32'd0);
      chk("rst ov_b", 32'(ov_b), 32'd0);
      chk("rst od_b", 32'(od_b), 32'(RVB));
      chk("rst rdy_b", 32'(rdy_b), 32'd1);
      chk("rst od_c", 32'(od_c), 32'(RVC));
      chk("rst rdy_c", 32'(rdy_c), 32'd1);
      for (int i = 0; i < 15; i++) begin
         set_in(tv[i].iv, tv[i].d, tv[i].r, tv[i].c);
         tick();
         chk($sformatf("vec%0d ov", i), 32'(ov_a), 32'(tv[i].ev));
         chk($sformatf("vec%0d od", i), od_a, tv[i].ed);
         chk($sformatf("vec%0d rdy", i), 32'(rdy_a), 32'(tv[i].er));
         chk($sformatf("vec%0d sc", i), 32'(sc_a), 32'(tv[i].es));
      end
      do_reset();
      set_in(1'b1, 32'hC5, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      repeat (7) tick();
      chk("pre-arst sc", 32'(sc_a), 32'd7);
      chk("pre-arst od", od_a, 32'hC5);
      #3 rst_n = 1'b0;
      #1;
      chk("arst ov", 32'(ov_a), 32'd0);
      chk("arst od", od_a, RVA);
      chk("arst sc", 32'(sc_a), 32'd0);
      chk("arst rdy", 32'(rdy_a), 32'd1);
      #2 rst_n = 1'b1;
      set_in(1'b1, 32'hC6, 1'b1, 1'b0);
      #1;
      chk("post-arst no comb ov", 32'(ov_a), 32'd0);
      tick();
      chk("post-arst ov", 32'(ov_a), 32'd1);
      chk("post-arst od", od_a, 32'hC6);
      do_reset();
      set_in(1'b1, 32'h77, 1'b0, 1'b0);
      tick();
      chk("sat load ov_b", 32'(ov_b), 32'd1);
      set_in(1'b0, '0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk($sformatf("sat k%0d", k), 32'(sc_b), (k < 15) ? 32'(k) : 32'd15);
      end
      chk("sat od_b held", 32'(od_b), 32'h77);
      chk("wide cnt no sat", 32'(sc_a), 32'd20);
      do_reset();
      set_in(1'b1, 32'hD0, 1'b0, 1'b0);
      #1 chk("skid0 empty rdy", 32'(rdy_c), 32'd1);
      tick();
      chk("skid0 load od", 32'(od_c), 32'hD0);
      set_in(1'b1, 32'hD9, 1'b0, 1'b0);
      #1 chk("skid0 bp rdy", 32'(rdy_c), 32'd0);
      tick();
      chk("skid0 held od", 32'(od_c), 32'hD0);
      chk("skid0 held ov", 32'(ov_c), 32'd1);
      set_in(1'b1, 32'hD1, 1'b1, 1'b0);
      #1 chk("skid0 pass rdy", 32'(rdy_c), 32'd1);
      tick();
      chk("skid0 next od", 32'(od_c), 32'hD1);
      do_reset();
      la = RVA; lc = RVC; ca = 0; cc = 0;
      repeat (400) begin
         set_in($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 4);
         #1;
         era = qa.size() < 2;
         erc = qc.size() == 0 || ordy;
         chk("rnd rdy_a", 32'(rdy_a), 32'(era));
         chk("rnd ov_a", 32'(ov_a), 32'(qa.size() > 0));
         chk("rnd od_a", od_a, la);
         chk("rnd sc_a", 32'(sc_a), 32'(ca));
         chk("rnd rdy_c", 32'(rdy_c), 32'(erc));
         chk("rnd ov_c", 32'(ov_c), 32'(qc.size() > 0));
         chk("rnd od_c", 32'(od_c), 32'(lc));
         chk("rnd sc_c", 32'(sc_c), 32'(cc));
         if (qa.size() > 0 && !ordy && ca < 65535) ca++;
         if (qc.size() > 0 && !ordy && cc < 255) cc++;
         if (clr) begin
            qa.delete(); qc.delete();
            la = RVA; lc = RVC;
         end else begin
            if (qa.size() > 0 && ordy) void'(qa.pop_front());
            if (qc.size() > 0 && ordy) void'(qc.pop_front());
            if (iv && era) qa.push_back(d);
            if (iv && erc) qc.push_back(d[15:0]);
            if (qa.size() > 0) la = qa[0];
            if (qc.size() > 0) lc = qc[0];
         end
         tick();
      end
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
